// File: rtl/pe_array_feeder.sv
// pe_array_feeder: transmit-side sequencer for a weight-stationary PE array.
// Loads ARRAY_DIM weight columns from the w_* stream, then streams num_vecs
// activation vectors from the x_* stream into the array. It counts returned
// psum_out_valid pulses and raises a one-cycle done pulse when the job is complete.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, num_vecs     job start (sampled in IDLE) and vector count (latched on start)
//   busy, done          job in progress / one-cycle completion pulse
//   w_valid/w_ready/w_data   weight column stream (slice r = row r)
//   x_valid/x_ready/x_data   activation vector stream (slice r = channel r)
//   weight_write_enable, weight_col, weight_in   registered weight-load port to array
//   data_in, data_valid                          registered data port to array
//   psum_out_valid      one pulse per completed result vector from the array
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; no beats accepted
// S_LOAD_W | accepting ARRAY_DIM weight columns
// S_STREAM | accepting activation vectors until num_vecs_q have been sent
// S_DRAIN  | all vectors sent; waiting for the remaining result pulses
module pe_array_feeder #(
  parameter int ARRAY_DIM  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_vecs,
  output logic                             busy,
  output logic                             done,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0]  w_data,
  input  logic                             x_valid,
  output logic                             x_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0]  x_data,
  output logic                             weight_write_enable,
  output logic [$clog2(ARRAY_DIM)-1:0]     weight_col,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0]  weight_in,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0]  data_in,
  output logic                             data_valid,
  input  logic                             psum_out_valid
);

  localparam int COL_W = $clog2(ARRAY_DIM);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN} state_t;

  state_t               state, state_d;
  logic [COL_W-1:0]     col_cnt;
  logic [CNT_WIDTH-1:0] num_vecs_q;
  logic [CNT_WIDTH-1:0] sent_cnt;
  logic [CNT_WIDTH-1:0] recv_cnt;

  logic w_acc, x_acc, psum_acc;
  logic last_col, last_vec, last_recv;

  // Ready decoded purely from registered state/counters.
  assign w_ready = (state == S_LOAD_W);
  assign x_ready = (state == S_STREAM) && (sent_cnt < num_vecs_q);

  assign w_acc     = w_valid && w_ready;
  assign x_acc     = x_valid && x_ready;
  assign last_col  = (col_cnt == COL_W'(ARRAY_DIM - 1));
  assign last_vec  = (sent_cnt == num_vecs_q - CNT_WIDTH'(1));
  assign last_recv = (recv_cnt == num_vecs_q - CNT_WIDTH'(1));

  // A result pulse is only meaningful for a vector already sent; anything
  // beyond sent_cnt is treated as spurious and dropped.
  assign psum_acc = psum_out_valid && ((state == S_STREAM) || (state == S_DRAIN)) &&
                    (recv_cnt < sent_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start && (num_vecs != '0)) state_d = S_LOAD_W;
      S_LOAD_W: if (w_acc && last_col)         state_d = S_STREAM;
      S_STREAM: if (x_acc && last_vec)         state_d = S_DRAIN;
      // recv_cnt < sent_cnt keeps completion out of S_STREAM.
      S_DRAIN:  if (psum_acc && last_recv)     state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt             <= '0;
      num_vecs_q          <= '0;
      sent_cnt            <= '0;
      recv_cnt            <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      weight_write_enable <= 1'b0;
      weight_col          <= '0;
      weight_in           <= '0;
      data_in             <= '0;
      data_valid          <= 1'b0;
    end else begin
      done                <= 1'b0;
      weight_write_enable <= 1'b0;
      data_valid          <= 1'b0;
      // Bubbles feed zeros into the array skew lines.
      data_in             <= '0;

      if ((state == S_IDLE) && start) begin
        if (num_vecs == '0) begin
          done <= 1'b1;
        end else begin
          num_vecs_q <= num_vecs;
          col_cnt    <= '0;
          sent_cnt   <= '0;
          recv_cnt   <= '0;
          busy       <= 1'b1;
        end
      end

      // weight_col/weight_in intentionally hold between beats.
      if (w_acc) begin
        weight_write_enable <= 1'b1;
        weight_col          <= col_cnt;
        weight_in           <= w_data;
        col_cnt             <= col_cnt + COL_W'(1);
      end

      if (x_acc) begin
        data_valid <= 1'b1;
        data_in    <= x_data;
        sent_cnt   <= sent_cnt + CNT_WIDTH'(1);
      end

      if (psum_acc) begin
        recv_cnt <= recv_cnt + CNT_WIDTH'(1);
        if ((state == S_DRAIN) && last_recv) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
module tb_pe_array_feeder;

  localparam int AD   = 16;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int BW   = AD * DW;
  localparam int COLW = $clog2(AD);

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_STREAM = 2;
  localparam int P_DRAIN  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_vecs;
  logic          busy, done;
  logic          w_valid, w_ready;
  logic [BW-1:0] w_data;
  logic          x_valid, x_ready;
  logic [BW-1:0] x_data;
  logic          weight_write_enable;
  logic [COLW-1:0] weight_col;
  logic [BW-1:0] weight_in;
  logic [BW-1:0] data_in;
  logic          data_valid;
  logic          psum_out_valid;

  pe_array_feeder #(.ARRAY_DIM(AD), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .num_vecs            (num_vecs),
    .busy                (busy),
    .done                (done),
    .w_valid             (w_valid),
    .w_ready             (w_ready),
    .w_data              (w_data),
    .x_valid             (x_valid),
    .x_ready             (x_ready),
    .x_data              (x_data),
    .weight_write_enable (weight_write_enable),
    .weight_col          (weight_col),
    .weight_in           (weight_in),
    .data_in             (data_in),
    .data_valid          (data_valid),
    .psum_out_valid      (psum_out_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: job phase plus beat/result counts, and the
  // values the array port must show in the cycle after each edge.
  int          ph;
  int unsigned m_nv, m_col, m_sent, m_recv;
  logic        e_busy, e_done, e_wwe, e_dv;
  logic [COLW-1:0] e_wcol;
  logic [BW-1:0]   e_win, e_din;

  // Behavioural array: stored weight columns and computed result columns.
  logic [BW-1:0] wmem [AD];
  int            res0_q[$];
  int            resl_q[$];
  logic [31:0]   dv_hist;
  int            lat;
  int            w_pat;
  logic [BW-1:0] x_list[$];

  function automatic logic [BW-1:0] rep(input logic [7:0] b);
    logic [BW-1:0] v;
    for (int i = 0; i < AD; i++) v[i*DW +: DW] = b;
    return v;
  endfunction

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    ph = P_IDLE; m_nv = 0; m_col = 0; m_sent = 0; m_recv = 0;
    e_busy = 0; e_done = 0; e_wwe = 0; e_dv = 0;
    e_wcol = '0; e_win = '0; e_din = '0;
  endtask

  task automatic check_outputs(input string pre);
    chk({pre, "_busy"},  BW'(busy), BW'(e_busy));
    chk({pre, "_done"},  BW'(done), BW'(e_done));
    chk({pre, "_wwe"},   BW'(weight_write_enable), BW'(e_wwe));
    chk({pre, "_wcol"},  BW'(weight_col), BW'(e_wcol));
    chk({pre, "_win"},   weight_in, e_win);
    chk({pre, "_dvalid"}, BW'(data_valid), BW'(e_dv));
    chk({pre, "_din"},   data_in, e_din);
  endtask

  task automatic observe();
    int r0, rl;
    if (weight_write_enable) wmem[weight_col] = weight_in;
    if (data_valid) begin
      r0 = 0; rl = 0;
      for (int r = 0; r < AD; r++) begin
        r0 += int'(wmem[0][r*DW +: DW]) * int'(data_in[r*DW +: DW]);
        rl += int'(wmem[AD-1][r*DW +: DW]) * int'(data_in[r*DW +: DW]);
      end
      res0_q.push_back(r0);
      resl_q.push_back(rl);
    end
    dv_hist = {dv_hist[30:0], data_valid};
  endtask

  // Inputs are already driven (at a falling edge); predict the next edge.
  task automatic tick();
    logic e_wr, e_xr;
    int   ph0;
    int unsigned old_sent;
    #1;
    if (rst) begin
      model_reset();
      check_outputs("rst");
    end
    e_wr = (ph == P_LOAD);
    e_xr = (ph == P_STREAM) && (m_sent < m_nv);
    chk("w_ready", BW'(w_ready), BW'(e_wr));
    chk("x_ready", BW'(x_ready), BW'(e_xr));
    if (!rst) begin
      e_done = 0; e_wwe = 0; e_dv = 0; e_din = '0;
      ph0 = ph;
      old_sent = m_sent;
      if ((ph0 == P_STREAM || ph0 == P_DRAIN) && psum_out_valid && (m_recv < old_sent)) begin
        m_recv++;
        if (m_recv == m_nv) begin
          e_done = 1; e_busy = 0; ph = P_IDLE;
        end
      end
      case (ph0)
        P_IDLE: if (start) begin
          if (num_vecs == 0) e_done = 1;
          else begin
            m_nv = num_vecs; m_col = 0; m_sent = 0; m_recv = 0;
            e_busy = 1; ph = P_LOAD;
          end
        end
        P_LOAD: if (w_valid) begin
          e_wwe = 1; e_wcol = COLW'(m_col); e_win = w_data;
          if (m_col == AD - 1) ph = P_STREAM;
          m_col++;
        end
        P_STREAM: if (x_valid && (old_sent < m_nv)) begin
          e_dv = 1; e_din = x_data;
          m_sent++;
          if (m_sent == m_nv) ph = P_DRAIN;
        end
        default: ;
      endcase
    end
    @(negedge clk);
    check_outputs("cyc");
    observe();
  endtask

  task automatic clear_inputs();
    start = 0; num_vecs = '0; w_valid = 0; x_valid = 0;
    w_data = '0; x_data = '0; psum_out_valid = 0;
  endtask

  task automatic drive_inputs(input int c, input int vmode, input int spur_pct);
    case (vmode)
      1: begin w_valid = 1; x_valid = 1; end
      2: begin w_valid = c[0]; x_valid = c[0]; end
      default: begin
        w_valid = ($urandom_range(99) < 60);
        x_valid = ($urandom_range(99) < 60);
      end
    endcase
    case (w_pat)
      1: w_data = rep(8'(m_col + 1));
      2: w_data = rep(8'd1);
      default: w_data = rnd_bus();
    endcase
    x_data = (x_list.size() > m_sent) ? x_list[m_sent] : rnd_bus();
    psum_out_valid = dv_hist[lat-1] | ($urandom_range(99) < spur_pct);
    // Stray starts while busy must be ignored.
    start    = ($urandom_range(9) == 0);
    num_vecs = CW'($urandom_range(7));
  endtask

  task automatic run_job(input int nv, input int vmode, input int spur_pct, input int budget);
    start = 1; num_vecs = CW'(nv);
    tick();
    start = 0;
    for (int c = 0; c < budget && ph != P_IDLE; c++) begin
      drive_inputs(c, vmode, spur_pct);
      tick();
    end
    clear_inputs();
    chk("job_end_busy", BW'(busy), BW'(0));
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    dv_hist = '0;
    lat = AD;
    w_pat = 0;
    for (int i = 0; i < AD; i++) wmem[i] = '0;

    // Reset held for 3 cycles under random inputs.
    @(negedge clk);
    repeat (3) begin
      start = $urandom_range(1); num_vecs = CW'($urandom);
      w_valid = $urandom_range(1); x_valid = $urandom_range(1);
      w_data = rnd_bus(); x_data = rnd_bus(); psum_out_valid = $urandom_range(1);
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();
    tick();

    // Back-to-back weight load, column k = bytes k+1.
    w_pat = 1;
    run_job(2, 1, 0, 200);

    // Gapped handshakes.
    w_pat = 0;
    run_job(5, 2, 0, 400);

    // End-to-end with a behavioural array: all weights 1, vectors 2,3,4.
    res0_q.delete(); resl_q.delete();
    w_pat = 2;
    x_list.push_back(rep(8'd2));
    x_list.push_back(rep(8'd3));
    x_list.push_back(rep(8'd4));
    lat = AD;
    run_job(3, 1, 0, 300);
    x_list.delete();
    chk("e2e_count", BW'(res0_q.size()), BW'(3));
    for (int i = 0; i < 3; i++) begin
      chk("e2e_col0", BW'(res0_q.size() > 0 ? res0_q.pop_front() : -1), BW'(32 + 16 * i));
      chk("e2e_collast", BW'(resl_q.size() > 0 ? resl_q.pop_front() : -1), BW'(32 + 16 * i));
    end
    w_pat = 0;

    // num_vecs = 0: immediate done, no loading.
    run_job(0, 1, 0, 10);
    w_valid = 1;
    repeat (3) tick();
    clear_inputs();

    // Mid-job reset after one of four vectors.
    start = 1; num_vecs = CW'(4);
    tick();
    start = 0;
    for (int c = 0; c < 100 && m_sent < 1; c++) begin
      drive_inputs(c, 1, 0);
      start = 0;
      tick();
    end
    chk("midjob_busy", BW'(busy), BW'(1));
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    repeat (3) tick();
    run_job(1, 1, 0, 200);

    // Spurious result pulses in IDLE.
    psum_out_valid = 1;
    repeat (5) tick();
    clear_inputs();

    // Randomized jobs with random gaps, latencies and stray pulses.
    for (int j = 0; j < 8; j++) begin
      lat = $urandom_range(1, 20);
      run_job($urandom_range(1, 6), (j % 2 == 0) ? 0 : 2, 3, 600);
      repeat (2) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Transmit-side sequencer for the 16x16 weight-stationary PE array; drives its weight-load and data inputs.
- Accepts weight columns and activation vectors from upstream valid/ready streams.
- Loads all ARRAY_DIM weight columns, then streams num_vecs activation vectors into the array.
- Counts returned psum_out_valid pulses and signals completion of the job.

Parameters:
- ARRAY_DIM, 16: array dimension; number of weight columns and bytes per vector.
- DATA_WIDTH, 8: width of each weight/activation element.
- CNT_WIDTH, 16: width of the vector and result counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job start; sampled only in IDLE.
- num_vecs  in  CNT_WIDTH  number of activation vectors in the job; latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat ready.
- w_data  in  ARRAY_DIM*DATA_WIDTH  one weight column per beat; slice r is the weight for row r.
- x_valid  in  1  activation beat valid.
- x_ready  out  1  activation beat ready.
- x_data  in  ARRAY_DIM*DATA_WIDTH  one activation vector; slice r is input channel r.
- weight_write_enable  out  1  to array.
- weight_col  out  $clog2(ARRAY_DIM)  to array.
- weight_in  out  ARRAY_DIM*DATA_WIDTH  to array.
- data_in  out  ARRAY_DIM*DATA_WIDTH  to array.
- data_valid  out  1  to array.
- psum_out_valid  in  1  from array; one pulse per completed result vector.

Behaviour:
- Reset (rst high, asynchronous): state=IDLE, all counters=0, every output=0 (busy, done, w_ready, x_ready, weight_write_enable, weight_col, weight_in, data_in, data_valid). This applies mid-job too: the job is abandoned and no done pulse is issued.
- All array-side outputs are registered. An accepted beat (valid&&ready at edge e) appears on the array outputs for exactly the cycle following e. w_ready/x_ready are decoded from registered state/counters; no combinational path from valid to ready.
- IDLE: w_ready=0, x_ready=0.
  - start && num_vecs!=0: latch num_vecs, clear col/sent/recv counters, busy<=1, go LOAD_W.
  - start && num_vecs==0: done<=1 for one cycle, busy stays 0, stay IDLE.
- LOAD_W: w_ready=1.
  - Each accepted beat: next cycle weight_write_enable=1, weight_col=col_cnt, weight_in=w_data; then col_cnt++.
  - Cycles without a beat: weight_write_enable=0; weight_col/weight_in hold their last value.
  - Acceptance of beat ARRAY_DIM-1: go STREAM. The first data_valid can be no earlier than one cycle after the last weight write.
- STREAM: x_ready=1 while sent_cnt<num_vecs_q.
  - Each accepted beat: next cycle data_valid=1, data_in=x_data; then sent_cnt++.
  - Bubbles: data_valid=0 and data_in=0, so zeros enter the array skew lines.
  - Acceptance of the last beat: x_ready drops in the same edge; go DRAIN.
- DRAIN: x_ready=0, data_valid=0, data_in=0.
- Result counting: recv_cnt increments on psum_out_valid in STREAM and DRAIN. When the increment makes recv_cnt==num_vecs_q: next cycle done=1 for one cycle, busy=0, go IDLE.
  - recv_cnt may reach num_vecs_q only in DRAIN. A pulse that would exceed sent_cnt is ignored.
  - psum_out_valid in IDLE or LOAD_W is ignored.
- start while busy: ignored. w_valid outside LOAD_W and x_valid outside STREAM: ignored; no beat consumed.
- Counters do not wrap. num_vecs up to 2^CNT_WIDTH-1 is supported.
- With the default array, results return ARRAY_DIM cycles after each data_valid. The feeder does not depend on that latency; it counts pulses only.

Test Plan:
- Reset: hold rst high 3 cycles with random inputs → all outputs 0. Release → w_ready=x_ready=0, busy=0.
- Back-to-back weight load: start with num_vecs=2, w_valid continuously high with column k = all bytes k+1 → weight_write_enable high 16 consecutive cycles, weight_col 0..15, weight_in bytes k+1; w_ready falls after the 16th beat.
- Gapped handshakes: w_valid and x_valid toggled every other cycle → weight_write_enable/data_valid pulse only on accepted beats, with no duplicate or skipped columns or vectors.
- End-to-end with a real pe_array:
  - Setup: all weights 1, num_vecs=3, x_data bytes all 2, then 3, then 4.
  - Result columns: 32, 48, 64 respectively.
  - done: one pulse after the 3rd psum_out_valid; busy falls in the same cycle.
- num_vecs=0: start → done pulse the next cycle, w_ready never asserts, busy stays 0.
- Mid-job reset and spurious pulses:
  - rst asserted after 1 of 4 vectors sent → outputs 0 immediately, no done.
  - Fresh start with num_vecs=1 completes normally.
  - Extra psum_out_valid pulses in IDLE cause no effect.
